// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline types for the hazard/stall controller: register addressing,
// the HiLo busy FSM encoding and the pipeline-control output bundle.
package hazard_stall_ctrl_pkg;

   localparam int REG_AW             = 5;
   localparam int MULDIV_LATENCY_DEF = 4;

   typedef logic [REG_AW-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = '0;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} busy_state_e;

   typedef struct packed {
      logic stall_or_not;
      logic pc_write_en;
      logic if_id_write_en;
      logic if_id_flush;
   } pipe_ctrl_t;

   // A source operand collides only if the instruction actually reads it.
   function automatic logic src_match(input logic uses, input reg_addr_t src,
                                      input reg_addr_t dst);
      return uses && (src == dst);
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ID/EXE hazard bus: decoded operand info from the pipeline in, stall/flush
// controls and debug status back out.
interface hazard_stall_ctrl_if
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int STAT_W = 16
);
   reg_addr_t          id_rs_addr;
   reg_addr_t          id_rt_addr;
   logic               id_uses_rs;
   logic               id_uses_rt;
   logic               id_reads_hilo;
   logic               id_is_muldiv;
   logic               ex_mem_read;
   reg_addr_t          ex_rt_addr;
   logic               ex_write_hilo;
   logic               ex_branch_taken;
   logic               stall_or_not;
   logic               pc_write_en;
   logic               if_id_write_en;
   logic               if_id_flush;
   logic               muldiv_busy;
   logic [STAT_W-1:0]  stall_cycles;

   modport master (
      output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_reads_hilo,
             id_is_muldiv, ex_mem_read, ex_rt_addr, ex_write_hilo, ex_branch_taken,
      input  stall_or_not, pc_write_en, if_id_write_en, if_id_flush,
             muldiv_busy, stall_cycles
   );

   modport slave (
      input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_reads_hilo,
             id_is_muldiv, ex_mem_read, ex_rt_addr, ex_write_hilo, ex_branch_taken,
      output stall_or_not, pc_write_en, if_id_write_en, if_id_flush,
             muldiv_busy, stall_cycles
   );
endinterface

// File: rtl/hazard_stall_ctrl_hilo_busy_counter.sv
// HiLo occupancy tracker: a HiLo-writing mul/div leaving EXE keeps the unit
// busy for MULDIV_LATENCY-1 further negedges.
module hilo_busy_counter
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int MULDIV_LATENCY = MULDIV_LATENCY_DEF,
   parameter int CNT_W          = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ex_write_hilo,
   output logic muldiv_busy
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LATENCY - 1);
   localparam bit               HAS_BUSY = (MULDIV_LATENCY > 1);

   busy_state_e       state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // A write while already busy restarts the window rather than being lost.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (ex_write_hilo && HAS_BUSY) begin
         state_nx = BUSY;
         cnt_nx   = CNT_LOAD;
      end else if (state == BUSY) begin
         if (cnt <= CNT_W'(1)) begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end else begin
            cnt_nx   = cnt - CNT_W'(1);
         end
      end
   end

   always_comb begin
      muldiv_busy = (state == BUSY);
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the ID/EXE boundary: load-use and HiLo
// stalls, taken-branch flush, and a saturating stall-cycle statistic.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int MULDIV_LATENCY = MULDIV_LATENCY_DEF,
   parameter int CNT_W          = 3,
   parameter int STAT_W         = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   hazard_stall_ctrl_if.slave  hz
);

   logic              muldiv_busy;
   logic              load_use;
   logic              hilo_hazard;
   logic              hazard;
   pipe_ctrl_t        ctrl;
   logic [STAT_W-1:0] stat_q;

   hilo_busy_counter #(
      .MULDIV_LATENCY (MULDIV_LATENCY),
      .CNT_W          (CNT_W)
   ) u_busy (
      .clk           (clk),
      .rst_n         (rst_n),
      .ex_write_hilo (hz.ex_write_hilo),
      .muldiv_busy   (muldiv_busy)
   );

   // $zero loads never create a dependency.
   assign load_use = hz.ex_mem_read && (hz.ex_rt_addr != REG_ZERO) &&
                     (src_match(hz.id_uses_rs, hz.id_rs_addr, hz.ex_rt_addr) ||
                      src_match(hz.id_uses_rt, hz.id_rt_addr, hz.ex_rt_addr));

   assign hilo_hazard = muldiv_busy && (hz.id_reads_hilo || hz.id_is_muldiv);
   assign hazard      = load_use || hilo_hazard;

   // Flush beats stall: the ID instruction is wrong-path, so let fetch advance.
   always_comb begin
      ctrl = '{stall_or_not: 1'b0, pc_write_en: 1'b1,
               if_id_write_en: 1'b1, if_id_flush: 1'b0};
      if (!rst_n) begin
         ctrl = '{stall_or_not: 1'b0, pc_write_en: 1'b1,
                  if_id_write_en: 1'b1, if_id_flush: 1'b0};
      end else if (hz.ex_branch_taken) begin
         ctrl = '{stall_or_not: 1'b1, pc_write_en: 1'b1,
                  if_id_write_en: 1'b1, if_id_flush: 1'b1};
      end else if (hazard) begin
         ctrl = '{stall_or_not: 1'b1, pc_write_en: 1'b0,
                  if_id_write_en: 1'b0, if_id_flush: 1'b0};
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_q <= '0;
      end else if (hazard && !hz.ex_branch_taken && (stat_q != '1)) begin
         stat_q <= stat_q + STAT_W'(1);
      end
   end

   assign hz.stall_or_not   = ctrl.stall_or_not;
   assign hz.pc_write_en    = ctrl.pc_write_en;
   assign hz.if_id_write_en = ctrl.if_id_write_en;
   assign hz.if_id_flush    = ctrl.if_id_flush;
   assign hz.muldiv_busy    = muldiv_busy;
   assign hz.stall_cycles   = stat_q;

endmodule
